// File: rtl/ysyx22041405_pkg.sv
// Shared types and constants for the ysyx22041405 instruction-fetch path.
package ysyx22041405_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  // Canonical NOP (addi x0, x0, 0) for consumers that substitute on !inst_valid.
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;

endpackage

// File: rtl/ysyx22041405_fetch_ctrl.sv
// Multi-cycle fetch controller: one outstanding imem request, a one-entry
// instruction buffer toward decode, and redirect handling that squashes the old path.
module ysyx22041405_fetch_ctrl
  import ysyx22041405_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_rsp_valid,
  output logic             imem_rsp_ready,
  input  logic [WIDTH-1:0] imem_rsp_data,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [WIDTH-1:0] inst,
  output logic [WIDTH-1:0] pc,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc
);

  fetch_state_t     state_q, state_d;
  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [WIDTH-1:0] req_addr_q, req_addr_d;
  logic [WIDTH-1:0] inst_q, inst_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             kill_q, kill_d;
  logic [WIDTH-1:0] redirect_aligned;

  assign redirect_aligned = {redirect_pc[WIDTH-1:2], 2'b00};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    kill_d     = kill_q;
    inst_d     = inst_q;
    pc_d       = pc_q;

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = REQ;
          end else begin
            inst_d     = imem_rsp_data;
            pc_d       = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + WIDTH'(4);
            state_d    = HOLD;
          end
        end
      end
      HOLD: begin
        if (inst_ready) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase

    // Redirect overrides everything above; any response seen this cycle is dropped.
    if (redirect_valid) begin
      fetch_pc_d = redirect_aligned;
      inst_d     = inst_q;
      pc_d       = pc_q;
      case (state_q)
        IDLE, HOLD: begin
          kill_d  = 1'b0;
          state_d = REQ;
        end
        REQ: begin
          kill_d  = 1'b1;
          state_d = imem_req_ready ? WAIT : REQ;
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            kill_d  = 1'b0;
            state_d = REQ;
          end else begin
            kill_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // A pending request keeps its address until accepted; otherwise track fetch_pc.
    if ((state_q == REQ) && (state_d == REQ)) begin
      req_addr_d = req_addr_q;
    end else begin
      req_addr_d = fetch_pc_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      kill_q     <= 1'b0;
      inst_q     <= '0;
      pc_q       <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      kill_q     <= kill_d;
      inst_q     <= inst_d;
      pc_q       <= pc_d;
    end
  end

  assign imem_req_valid = (state_q == REQ);
  assign imem_rsp_ready = (state_q == WAIT);
  assign inst_valid     = (state_q == HOLD);
  assign imem_req_addr  = (state_q == REQ) ? req_addr_q : fetch_pc_q;
  assign inst           = inst_q;
  assign pc             = pc_q;

endmodule

// File: tb/tb_ysyx22041405_fetch_ctrl.sv
// Directed bench for ysyx22041405_fetch_ctrl: cycle table, streaming memory model, reset cases.
module tb_ysyx22041405_fetch_ctrl;

  localparam logic [31:0] RPC  = 32'h8000_0000;
  localparam logic [31:0] XPAT = 32'hA5A5_0000;
  localparam int          NV   = 28;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid, imem_rsp_ready;
  logic [31:0] imem_rsp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ysyx22041405_fetch_ctrl #(.WIDTH(32), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_ready(imem_rsp_ready),
    .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .pc(pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  typedef struct {
    logic        rr, sv;
    logic [31:0] sd;
    logic        ir, rv;
    logic [31:0] rp;
    logic        e_rv, e_sr, e_iv;
    logic [31:0] e_addr, e_inst, e_pc;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(logic rr, logic sv, logic [31:0] sd, logic ir, logic rv,
                              logic [31:0] rp, logic e_rv, logic e_sr, logic e_iv,
                              logic [31:0] e_addr, logic [31:0] e_inst, logic [31:0] e_pc);
    vec_t v;
    v.rr = rr; v.sv = sv; v.sd = sd; v.ir = ir; v.rv = rv; v.rp = rp;
    v.e_rv = e_rv; v.e_sr = e_sr; v.e_iv = e_iv;
    v.e_addr = e_addr; v.e_inst = e_inst; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
  endtask

  // Leaves rst released right at a falling edge with the DUT in IDLE.
  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Zero-wait memory returning addr^XPAT, decode stalled 5 cycles on the 4th instruction.
  task automatic run_stream();
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;
    logic        p_rv = 1'b0, p_rr = 1'b0, p_sr = 1'b0, p_sv = 1'b0, p_iv = 1'b0, p_ir = 1'b0;
    logic [31:0] p_addr = '0;
    logic [31:0] exp_pc;
    int          k = 0, last = -1, stall = 0;
    for (int cyc = 0; cyc < 200 && k < 6; cyc++) begin
      if (cyc != 0) @(negedge clk);
      if (p_rv && p_rr) begin pend = 1'b1; pend_addr = p_addr; end
      if (p_sr && p_sv) pend = 1'b0;
      exp_pc = RPC + 32'(4 * k);
      if (inst_valid && !(p_iv && !p_ir)) begin
        chk("stream_pc", pc, exp_pc);
        chk("stream_inst", inst, exp_pc ^ XPAT);
        if (k >= 1 && k <= 3) chk("stream_spacing", 32'(cyc - last), 32'd3);
        $display("stream inst %0d: cycle %0d pc %h inst %h", k, cyc, pc, inst);
        last = cyc;
        if (k == 3) stall = 6;
        k++;
      end else if (stall > 0) begin
        chk("stall_inst_valid", {31'd0, inst_valid}, 32'd1);
        chk("stall_no_req", {31'd0, imem_req_valid}, 32'd0);
        chk("stall_pc", pc, RPC + 32'd12);
        chk("stall_inst", inst, (RPC + 32'd12) ^ XPAT);
      end
      if (stall > 0) stall--;
      if (imem_req_valid && pend) chk("one_outstanding", 32'd1, 32'd0);
      imem_req_ready = 1'b1;
      imem_rsp_valid = pend;
      imem_rsp_data  = pend_addr ^ XPAT;
      inst_ready     = (stall == 0);
      p_rv = imem_req_valid; p_rr = imem_req_ready; p_addr = imem_req_addr;
      p_sr = imem_rsp_ready; p_sv = imem_rsp_valid;
      p_iv = inst_valid;     p_ir = inst_ready;
    end
    if (k < 6) chk("stream_timeout_insts", 32'(k), 32'd6);
  endtask

  initial begin
    vecs[0]  = mk(0,0,32'h0,0,0,32'h0,              0,0,0, 32'h8000_0000, 32'h0,         32'h8000_0000);
    vecs[1]  = mk(1,0,32'h0,0,0,32'h0,              1,0,0, 32'h8000_0000, 32'h0,         32'h8000_0000);
    vecs[2]  = mk(0,1,32'h1111_1111,0,0,32'h0,      0,1,0, 32'h8000_0000, 32'h0,         32'h8000_0000);
    vecs[3]  = mk(0,0,32'h0,1,0,32'h0,              0,0,1, 32'h8000_0004, 32'h1111_1111, 32'h8000_0000);
    vecs[4]  = mk(0,0,32'h0,0,0,32'h0,              1,0,0, 32'h8000_0004, 32'h1111_1111, 32'h8000_0000);
    vecs[5]  = mk(0,0,32'h0,0,1,32'h9000_0003,      1,0,0, 32'h8000_0004, 32'h1111_1111, 32'h8000_0000);
    vecs[6]  = mk(1,0,32'h0,0,0,32'h0,              1,0,0, 32'h8000_0004, 32'h1111_1111, 32'h8000_0000);
    vecs[7]  = mk(0,1,32'h0000_DEAD,0,0,32'h0,      0,1,0, 32'h9000_0000, 32'h1111_1111, 32'h8000_0000);
    vecs[8]  = mk(1,0,32'h0,0,0,32'h0,              1,0,0, 32'h9000_0000, 32'h1111_1111, 32'h8000_0000);
    vecs[9]  = mk(0,0,32'h0,0,0,32'h0,              0,1,0, 32'h9000_0000, 32'h1111_1111, 32'h8000_0000);
    vecs[10] = mk(0,1,32'h2222_2222,0,0,32'h0,      0,1,0, 32'h9000_0000, 32'h1111_1111, 32'h8000_0000);
    vecs[11] = mk(0,0,32'h0,0,0,32'h0,              0,0,1, 32'h9000_0004, 32'h2222_2222, 32'h9000_0000);
    vecs[12] = mk(0,0,32'h0,1,1,32'hFFFF_FFFC,      0,0,1, 32'h9000_0004, 32'h2222_2222, 32'h9000_0000);
    vecs[13] = mk(1,0,32'h0,0,0,32'h0,              1,0,0, 32'hFFFF_FFFC, 32'h2222_2222, 32'h9000_0000);
    vecs[14] = mk(0,1,32'h3333_3333,0,0,32'h0,      0,1,0, 32'hFFFF_FFFC, 32'h2222_2222, 32'h9000_0000);
    vecs[15] = mk(0,0,32'h0,1,0,32'h0,              0,0,1, 32'h0000_0000, 32'h3333_3333, 32'hFFFF_FFFC);
    vecs[16] = mk(1,0,32'h0,0,0,32'h0,              1,0,0, 32'h0000_0000, 32'h3333_3333, 32'hFFFF_FFFC);
    vecs[17] = mk(0,0,32'h0,0,1,32'h8000_0102,      0,1,0, 32'h0000_0000, 32'h3333_3333, 32'hFFFF_FFFC);
    vecs[18] = mk(0,0,32'h0,0,0,32'h0,              0,1,0, 32'h8000_0100, 32'h3333_3333, 32'hFFFF_FFFC);
    vecs[19] = mk(0,0,32'h0,0,0,32'h0,              0,1,0, 32'h8000_0100, 32'h3333_3333, 32'hFFFF_FFFC);
    vecs[20] = mk(0,1,32'h4444_4444,0,0,32'h0,      0,1,0, 32'h8000_0100, 32'h3333_3333, 32'hFFFF_FFFC);
    vecs[21] = mk(1,0,32'h0,0,0,32'h0,              1,0,0, 32'h8000_0100, 32'h3333_3333, 32'hFFFF_FFFC);
    vecs[22] = mk(0,1,32'h5555_5555,0,1,32'hA000_0000, 0,1,0, 32'h8000_0100, 32'h3333_3333, 32'hFFFF_FFFC);
    vecs[23] = mk(1,0,32'h0,0,0,32'h0,              1,0,0, 32'hA000_0000, 32'h3333_3333, 32'hFFFF_FFFC);
    vecs[24] = mk(0,1,32'h6666_6666,0,0,32'h0,      0,1,0, 32'hA000_0000, 32'h3333_3333, 32'hFFFF_FFFC);
    vecs[25] = mk(0,0,32'h0,0,0,32'h0,              0,0,1, 32'hA000_0004, 32'h6666_6666, 32'hA000_0000);
    vecs[26] = mk(0,0,32'h0,0,1,32'hB000_0001,      0,0,1, 32'hA000_0004, 32'h6666_6666, 32'hA000_0000);
    vecs[27] = mk(0,0,32'h0,0,0,32'h0,              1,0,0, 32'hB000_0000, 32'h6666_6666, 32'hA000_0000);

    // Cycle table: outputs reflect registered state, so they are checked before the edge.
    do_reset();
    for (int i = 0; i < NV; i++) begin
      imem_req_ready = vecs[i].rr; imem_rsp_valid = vecs[i].sv; imem_rsp_data = vecs[i].sd;
      inst_ready = vecs[i].ir; redirect_valid = vecs[i].rv; redirect_pc = vecs[i].rp;
      #1;
      chk($sformatf("v%0d_req_valid", i), {31'd0, imem_req_valid}, {31'd0, vecs[i].e_rv});
      chk($sformatf("v%0d_rsp_ready", i), {31'd0, imem_rsp_ready}, {31'd0, vecs[i].e_sr});
      chk($sformatf("v%0d_inst_valid", i), {31'd0, inst_valid}, {31'd0, vecs[i].e_iv});
      chk($sformatf("v%0d_req_addr", i), imem_req_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_inst", i), inst, vecs[i].e_inst);
      chk($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
      $display("vec %0d: req_v=%0b rsp_r=%0b inst_v=%0b addr=%h inst=%h pc=%h",
               i, imem_req_valid, imem_rsp_ready, inst_valid, imem_req_addr, inst, pc);
      @(negedge clk);
    end

    do_reset();
    run_stream();

    // Reset asserted mid-stream clears state without waiting for a clock edge.
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("async_rst_rsp_ready", {31'd0, imem_rsp_ready}, 32'd0);
    chk("async_rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("async_rst_inst", inst, 32'd0);
    chk("async_rst_pc", pc, RPC);
    chk("async_rst_addr", imem_req_addr, RPC);
    $display("async reset: req_v=%0b inst=%h pc=%h", imem_req_valid, inst, pc);
    clear_inputs();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h1234_5677;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("idle_redir_pre_req_valid", {31'd0, imem_req_valid}, 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk("idle_redir_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("idle_redir_addr", imem_req_addr, 32'h1234_5674);
    $display("idle redirect: req_v=%0b addr=%h", imem_req_valid, imem_req_addr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
